// File: rtl/pc_fetch_unit.sv
// rtl/pc_fetch_unit.sv - PC owner and single-outstanding instruction-memory request unit
//
// Owns the program counter, issues one word request at a time to instruction
// memory and presents each returned instruction, with its PC, to the fetch
// latch. A bubble (fetch_nop=1, NOP_WORD) is driven whenever no valid
// instruction is available.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   stall               downstream hold; fetch outputs freeze
//   redirect_valid/pc   taken branch/jump; flushes and reloads the PC
//   imem_req_*          request channel (valid/ready, word address)
//   imem_rsp_*          response channel (no backpressure)
//   fetch_pc            PC of the presented instruction
//   fetch_instruction   presented instruction (NOP_WORD during bubbles)
//   fetch_nop           1 = bubble
`timescale 1ns/1ps

module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_WORD = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic [31:0] fetch_pc,
    output logic [31:0] fetch_instruction,
    output logic        fetch_nop
);

    typedef enum logic [1:0] {
        S_BOOT = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DROP = 2'd3
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic [31:0] pc_q;
    logic [31:0] out_pc_q;
    logic        hold_valid;
    logic [31:0] hold_pc;
    logic [31:0] hold_instr;

    logic        handshake;
    logic        redirect_take;
    logic        rsp_accept;

    // A pending held instruction blocks issue, so the hold buffer never
    // needs more than one entry.
    assign imem_req_valid = (state_q == S_REQ) && !hold_valid;
    assign imem_req_addr  = pc_q;

    assign handshake     = imem_req_valid && imem_req_ready;
    // Redirects are meaningless before the first request has been set up.
    assign redirect_take = redirect_valid && (state_q != S_BOOT);
    // Only a response to a live (non-flushed) request is kept.
    assign rsp_accept    = (state_q == S_WAIT) && imem_rsp_valid && !redirect_take;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_BOOT: state_d = S_REQ;
            S_REQ: begin
                if (handshake) begin
                    state_d = redirect_take ? S_DROP : S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_rsp_valid) begin
                    state_d = S_REQ;
                end else if (redirect_take) begin
                    state_d = S_DROP;
                end
            end
            S_DROP: begin
                if (imem_rsp_valid) begin
                    state_d = S_REQ;
                end
            end
            default: state_d = S_BOOT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_BOOT;
        end else begin
            state_q <= state_d;
        end
    end

    // PC and outstanding-request bookkeeping. Redirect wins over the
    // sequential increment even when a handshake happens in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q     <= RESET_PC;
            out_pc_q <= RESET_PC;
        end else begin
            if (handshake) begin
                out_pc_q <= pc_q;
            end
            if (redirect_take) begin
                pc_q <= redirect_pc & 32'hFFFF_FFFC;
            end else if (handshake) begin
                pc_q <= pc_q + 32'd4;
            end
        end
    end

    // Hold buffer and fetch-latch outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_valid        <= 1'b0;
            hold_pc           <= RESET_PC;
            hold_instr        <= NOP_WORD;
            fetch_pc          <= RESET_PC;
            fetch_instruction <= NOP_WORD;
            fetch_nop         <= 1'b1;
        end else if (redirect_take) begin
            // Flush: drop any held instruction and bubble even under stall.
            hold_valid        <= 1'b0;
            fetch_instruction <= NOP_WORD;
            fetch_nop         <= 1'b1;
        end else if (!stall) begin
            if (hold_valid) begin
                hold_valid        <= 1'b0;
                fetch_pc          <= hold_pc;
                fetch_instruction <= hold_instr;
                fetch_nop         <= 1'b0;
            end else if (rsp_accept) begin
                fetch_pc          <= out_pc_q;
                fetch_instruction <= imem_rsp_data;
                fetch_nop         <= 1'b0;
            end else begin
                fetch_instruction <= NOP_WORD;
                fetch_nop         <= 1'b1;
            end
        end else if (rsp_accept) begin
            // Outputs frozen; park the response until the stall releases.
            hold_valid <= 1'b1;
            hold_pc    <= out_pc_q;
            hold_instr <= imem_rsp_data;
        end
    end

endmodule

// File: doc/pc_fetch_unit.md
# pc_fetch_unit

Program-counter and instruction-memory request unit sitting directly upstream of the fetch latch stage. It owns the PC and issues one-at-a-time word requests to instruction memory. It accepts branch/jump redirects and stalls, and presents each returned instruction with its PC. It drives the fetch latch's instruction, PC and NOP-select inputs, inserting a bubble whenever no valid instruction is available.

## Interface
- RESET_PC, 32'h0000_0000, PC of the first request after reset
- NOP_WORD, 32'h0000_0013, instruction driven during bubbles (addi x0,x0,0, equal to `NOP_INSTRUCTION`)

- clk  in  1  clock; all state updates on posedge
- rst_n  in  1  reset, asynchronous, active-low
- stall  in  1  downstream hold; outputs freeze
- redirect_valid  in  1  taken branch/jump; flush and reload PC
- redirect_pc  in  32  new PC; bits [1:0] forced to 0
- imem_req_valid  out  1  request valid
- imem_req_addr  out  32  request word address
- imem_req_ready  in  1  memory accepts request
- imem_rsp_valid  in  1  response valid; no backpressure
- imem_rsp_data  in  32  response instruction
- fetch_pc  out  32  PC of presented instruction (to fetch latch pc_in)
- fetch_instruction  out  32  presented instruction (to fetch latch input_instruction)
- fetch_nop  out  1  1 = bubble (to fetch latch nop_output)

## Operation
- Registers:
  - pc_q: next request address.
  - out_pc_q: PC of the outstanding request.
  - hold buffer: hold_valid, hold_pc, hold_instr.
  - FSM state.
  - Output registers.
- FSM states: BOOT, REQ, WAIT, DROP. At most one request outstanding.
- imem_req_valid = (state==REQ) && !hold_valid. imem_req_addr = pc_q.
- BOOT -> REQ on first posedge after rst_n rises.
- REQ, handshake (valid&ready):
  - out_pc_q<=pc_q, pc_q<=pc_q+4 (mod 2^32).
  - Next state WAIT, or DROP if redirect_valid in the same cycle.
- WAIT:
  - rsp_valid & !redirect -> REQ. Instruction goes to the outputs if stall=0, else to the hold buffer.
  - rsp_valid & redirect -> REQ, data discarded.
  - !rsp_valid & redirect -> DROP.
- DROP: rsp_valid -> REQ, data discarded. A redirect in DROP updates pc_q and stays in DROP.
- Redirect (any state except BOOT):
  - pc_q<=redirect_pc & ~3.
  - hold_valid<=0.
  - Outputs become a bubble regardless of stall.
  - Redirect has priority over every other event.
- Redirect is the only event allowed to change imem_req_addr while imem_req_valid=1 without a handshake.
- Output update, stall=0 and no redirect, first match wins:
  - hold_valid: present hold_pc/hold_instr, fetch_nop=0, clear hold.
  - Accepted response: present out_pc_q/imem_rsp_data, fetch_nop=0.
  - Otherwise bubble: fetch_nop=1, fetch_instruction=NOP_WORD, fetch_pc held.
- stall=1 and no redirect: outputs hold their values. A response arriving under stall fills the hold buffer. Because hold_valid blocks issue, the buffer cannot overflow.

## Timing
- Reset values:
  - state=BOOT, imem_req_valid=0, pc_q=RESET_PC, hold_valid=0.
  - fetch_pc=RESET_PC, fetch_instruction=NOP_WORD, fetch_nop=1.
- Reset mid-operation: all registers return to reset values immediately (async). Any outstanding response arriving during or after reset is ignored, since state is BOOT/REQ.
- Outputs are registered on posedge and stable by the fetch latch's negedge sample in the same cycle.
- Responses arrive at least 1 cycle after acceptance. A response in the same cycle as its request is illegal.
- Zero-wait memory:
  - Request accepted at edge n, response during cycle n+1, outputs updated at edge n+1.
  - Peak throughput is 1 instruction per 2 cycles, with a bubble between instructions.
- Redirect at edge n: the first request to redirect_pc asserts in cycle n+1 if state is REQ, or after the stale response drains (DROP).
- PC wrap: 32'hFFFF_FFFC + 4 = 32'h0000_0000.

## Test plan
- Reset with RESET_PC=32'h100, zero-wait memory -> requests to 0x100, 0x104, 0x108; fetch outputs (0x100,I0,nop=0), bubble, (0x104,I1,nop=0).
- stall=1 while WAIT response I0 arrives -> outputs frozen, no new request. Release stall -> I0 presented next edge, request 0x104 the following cycle.
- Redirect to 0x200 while in WAIT, response arrives 3 cycles later -> response discarded (DROP), fetch_nop=1, next request address 0x200.
- Redirect to 0x40 in the same cycle as a handshake at 0x10 -> 0x10 response dropped, next request 0x40.
- redirect_pc=32'hFFFF_FFFC -> requests 0xFFFF_FFFC then 0x0000_0000.
- rst_n low for one cycle during WAIT -> outputs immediately at reset values, imem_req_valid=0, a late response is ignored, restart from RESET_PC.
